// File: rtl/ax_adder_pkg.sv
// Shared defaults and the exact reference adder for the approximate streaming adder.
package ax_adder_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_K     = 4;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned REF_W     = 64;

    // Exact {carry, sum} of a + b + cin; callers narrower than REF_W zero-extend
    // operands and read their carry at bit position WIDTH.
    function automatic logic [REF_W:0] ref_add(
        input logic [REF_W-1:0] a,
        input logic [REF_W-1:0] b,
        input logic             cin
    );
        return (REF_W+1)'(a) + (REF_W+1)'(b) + (REF_W+1)'(cin);
    endfunction

endpackage

// File: rtl/bk_prefix_approx.sv
// Brent-Kung carry network; in approximate mode the low K bits generate only.
module bk_prefix_approx #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned K     = 4
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    input  logic             cin,
    input  logic             approx,
    output logic [WIDTH:0]   carry
);

    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    logic             kill_low;
    logic             c0;

    always_comb begin
        gg       = g;
        pp       = p;
        kill_low = approx && (K > 0);
        c0       = kill_low ? 1'b0 : cin;

        // Killing propagate below K makes bit K-1's prefix equal g_{K-1},
        // which then seeds the exact upper prefix.
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (kill_low && (i < int'(K))) begin
                pp[i] = 1'b0;
            end
        end

        gg[0] = gg[0] | (pp[0] & c0);

        // Up-sweep: group terms at indices 2d-1, 4d-1, ...
        for (int d = 1; d < int'(WIDTH); d = d * 2) begin
            for (int i = 2 * d - 1; i < int'(WIDTH); i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end

        // Down-sweep: fill the remaining prefixes from the completed ones.
        for (int d = int'(WIDTH); d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < int'(WIDTH); i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end

        carry = {gg, c0};
    end

endmodule

// File: rtl/approx_bk_adder_pipe.sv
// Two-stage valid/ready approximate Brent-Kung adder with per-beat error flag and counter.
module approx_bk_adder_pipe
    import ax_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned K     = DEF_K,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
    input  logic             Approx_En,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_Out,
    output logic             Err,
    output logic [CNT_W-1:0] Err_Count,
    input  logic             Clr_Count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic             s1_approx;

    logic             s1_load;
    logic             s2_load;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   carry_ax;
    logic [WIDTH:0]   carry_ex;
    logic [WIDTH-1:0] sum_ax;
    logic [WIDTH-1:0] sum_ex;
    logic             err_now;

    always_comb begin
        s2_load  = !Out_Valid || Out_Ready;
        s1_load  = !s1_valid || s2_load;
        In_Ready = s1_load;
    end

    // Stage 1: operand capture
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_cin    <= 1'b0;
            s1_approx <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= In_Valid;
            if (In_Valid) begin
                s1_a      <= A;
                s1_b      <= B;
                s1_cin    <= Carry_in;
                s1_approx <= Approx_En;
            end
        end
    end

    always_comb begin
        p = s1_a ^ s1_b;
        g = s1_a & s1_b;
    end

    bk_prefix_approx #(
        .WIDTH (WIDTH),
        .K     (K)
    ) u_prefix_ax (
        .p      (p),
        .g      (g),
        .cin    (s1_cin),
        .approx (s1_approx),
        .carry  (carry_ax)
    );

    // Reference network: K=0 is always exact and honours Carry_in.
    bk_prefix_approx #(
        .WIDTH (WIDTH),
        .K     (0)
    ) u_prefix_ex (
        .p      (p),
        .g      (g),
        .cin    (s1_cin),
        .approx (1'b0),
        .carry  (carry_ex)
    );

    always_comb begin
        sum_ax  = p ^ carry_ax[WIDTH-1:0];
        sum_ex  = p ^ carry_ex[WIDTH-1:0];
        err_now = {carry_ax[WIDTH], sum_ax} != {carry_ex[WIDTH], sum_ex};
    end

    // Stage 2: result registers; a bubble only clears Out_Valid
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Out_Valid <= 1'b0;
            Sum       <= '0;
            Carry_Out <= 1'b0;
            Err       <= 1'b0;
        end else if (s2_load) begin
            Out_Valid <= s1_valid;
            if (s1_valid) begin
                Sum       <= sum_ax;
                Carry_Out <= carry_ax[WIDTH];
                Err       <= err_now;
            end
        end
    end

    // Saturating mismatch counter; clear wins over a same-cycle increment
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Err_Count <= '0;
        end else if (Clr_Count) begin
            Err_Count <= '0;
        end else if (Out_Valid && Out_Ready && Err && (Err_Count != CNT_MAX)) begin
            Err_Count <= Err_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_approx_bk_adder_pipe.sv
// Directed bench for approx_bk_adder_pipe (WIDTH=16, K=4, CNT_W=2).
module tb_approx_bk_adder_pipe;
    import ax_adder_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned KK = 4;
    localparam int unsigned CW = 2;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Carry_in = 1'b0;
    logic          Approx_En = 1'b0;
    logic          Out_Valid;
    logic          Out_Ready = 1'b1;
    logic [W-1:0]  Sum;
    logic          Carry_Out;
    logic          Err;
    logic [CW-1:0] Err_Count;
    logic          Clr_Count = 1'b0;

    int checks = 0;
    int failures = 0;

    approx_bk_adder_pipe #(
        .WIDTH (W),
        .K     (KK),
        .CNT_W (CW)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .A         (A),
        .B         (B),
        .Carry_in  (Carry_in),
        .Approx_En (Approx_En),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Sum       (Sum),
        .Carry_Out (Carry_Out),
        .Err       (Err),
        .Err_Count (Err_Count),
        .Clr_Count (Clr_Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic ax);
        In_Valid  = 1'b1;
        A         = a;
        B         = b;
        Carry_in  = cin;
        Approx_En = ax;
    endtask

    // Called at a falling edge; returns at the falling edge where the result is valid.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic ax);
        drive(a, b, cin, ax);
        @(negedge Clk);
        In_Valid = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [REF_W:0] r;

        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_out_valid", 32'(Out_Valid), 32'h0);
        chk("rst_sum", 32'(Sum), 32'h0);
        chk("rst_cout", 32'(Carry_Out), 32'h0);
        chk("rst_err", 32'(Err), 32'h0);
        chk("rst_count", 32'(Err_Count), 32'h0);
        chk("rst_in_ready", 32'(In_Ready), 32'h1);

        // Low-bit carry is dropped in approximate mode
        run_one(16'h000F, 16'h0001, 1'b0, 1'b1);
        chk("t1ax_valid", 32'(Out_Valid), 32'h1);
        chk("t1ax_sum", 32'(Sum), 32'h000C);
        chk("t1ax_cout", 32'(Carry_Out), 32'h0);
        chk("t1ax_err", 32'(Err), 32'h1);
        @(negedge Clk);
        chk("t1ax_count", 32'(Err_Count), 32'h1);
        chk("t1_bubble", 32'(Out_Valid), 32'h0);

        run_one(16'h000F, 16'h0001, 1'b0, 1'b0);
        chk("t1ex_sum", 32'(Sum), 32'h0010);
        chk("t1ex_err", 32'(Err), 32'h0);

        // g_3 seeds the exact upper prefix
        run_one(16'h00F8, 16'h0008, 1'b0, 1'b1);
        chk("t2_sum", 32'(Sum), 32'h0100);
        chk("t2_err", 32'(Err), 32'h0);

        run_one(16'h0000, 16'h0000, 1'b1, 1'b1);
        chk("t3ax_sum", 32'(Sum), 32'h0000);
        chk("t3ax_err", 32'(Err), 32'h1);
        @(negedge Clk);
        chk("t3ax_count", 32'(Err_Count), 32'h2);

        run_one(16'h0000, 16'h0000, 1'b1, 1'b0);
        chk("t3ex_sum", 32'(Sum), 32'h0001);

        run_one(16'hFFFF, 16'h0010, 1'b0, 1'b1);
        chk("t3c_sum", 32'(Sum), 32'h000F);
        chk("t3c_cout", 32'(Carry_Out), 32'h1);
        chk("t3c_err", 32'(Err), 32'h0);

        // Backpressure: two beats held, third waits on In_Ready
        @(negedge Clk);
        Out_Ready = 1'b0;
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        chk("bp_ready0", 32'(In_Ready), 32'h1);
        @(negedge Clk);
        chk("bp_ready1", 32'(In_Ready), 32'h1);
        drive(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        @(negedge Clk);
        chk("bp_ready_full", 32'(In_Ready), 32'h0);
        chk("bp_valid", 32'(Out_Valid), 32'h1);
        chk("bp_sum0", 32'(Sum), 32'h2345);
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge Clk);
        chk("bp_sum0_stable", 32'(Sum), 32'h2345);
        chk("bp_ready_held", 32'(In_Ready), 32'h0);
        Out_Ready = 1'b1;
        @(negedge Clk);
        In_Valid = 1'b0;
        chk("bp_valid1", 32'(Out_Valid), 32'h1);
        chk("bp_sum1", 32'(Sum), 32'h1000);
        chk("bp_cout1", 32'(Carry_Out), 32'h0);
        @(negedge Clk);
        chk("bp_valid2", 32'(Out_Valid), 32'h1);
        chk("bp_sum2", 32'(Sum), 32'h0000);
        chk("bp_cout2", 32'(Carry_Out), 32'h1);
        @(negedge Clk);
        chk("bp_drained", 32'(Out_Valid), 32'h0);

        // Counter saturation at 2^CNT_W-1
        Clr_Count = 1'b1;
        @(negedge Clk);
        Clr_Count = 1'b0;
        chk("sat_cleared", 32'(Err_Count), 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(16'h0000, 16'h0000, 1'b1, 1'b1);
            @(negedge Clk);
        end
        In_Valid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("sat_count", 32'(Err_Count), 32'h3);

        // Clear beats a same-cycle increment
        run_one(16'h0000, 16'h0000, 1'b1, 1'b1);
        chk("clr_err", 32'(Err), 32'h1);
        Clr_Count = 1'b1;
        @(negedge Clk);
        Clr_Count = 1'b0;
        chk("clr_priority", 32'(Err_Count), 32'h0);

        // Asynchronous reset with two beats in flight
        run_one(16'h0000, 16'h0000, 1'b1, 1'b1);
        @(negedge Clk);
        chk("mid_count_pre", 32'(Err_Count), 32'h1);
        Out_Ready = 1'b0;
        drive(16'h0001, 16'h0002, 1'b0, 1'b0);
        @(negedge Clk);
        drive(16'h0003, 16'h0004, 1'b0, 1'b0);
        @(negedge Clk);
        In_Valid = 1'b0;
        chk("mid_inflight", 32'(Out_Valid), 32'h1);
        chk("mid_full", 32'(In_Ready), 32'h0);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(Out_Valid), 32'h0);
        chk("mid_rst_count", 32'(Err_Count), 32'h0);
        chk("mid_rst_sum", 32'(Sum), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        Out_Ready = 1'b1;
        chk("mid_in_ready", 32'(In_Ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("mid_no_stale", 32'(Out_Valid), 32'h0);
        end

        // Exact mode against the package reference
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_one(ra, rb, rc, 1'b0);
            r = ref_add(REF_W'(ra), REF_W'(rb), rc);
            chk("rnd_sum", 32'(Sum), 32'(r[W-1:0]));
            chk("rnd_cout", 32'(Carry_Out), 32'(r[W]));
            chk("rnd_err", 32'(Err), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
